// File: rtl/button_debounce_pkg.sv
// Shared types and board defaults for the push-button debouncer.
package button_debounce_pkg;

    // Debouncer FSM: released, confirming press, pressed, confirming release.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // Defaults for the 25 MHz oscillator: 20 ms debounce, 1 s long press.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500_000;
    localparam int DEFAULT_LONG_CYCLES     = 25_000_000;

endpackage : button_debounce_pkg

// File: rtl/button_debounce_if.sv
// Button pad plus debounced level/event outputs.
// master: the side driving the pad and consuming events; slave: the debouncer.
interface button_debounce_if;

    logic btn_n;            // raw pad, active low, asynchronous
    logic btn_level;        // debounced level, 1 = pressed
    logic press_pulse;      // one cycle per debounced press
    logic release_pulse;    // one cycle per debounced release
    logic long_press_pulse; // one cycle per press held long enough

    modport master (
        output btn_n,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  long_press_pulse
    );

    modport slave (
        input  btn_n,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output long_press_pulse
    );

endinterface : button_debounce_if

// File: rtl/button_debounce_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous pad input.
// RESET_VAL selects the idle level the flops return to on reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the pad through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses <= so both flops sample pre-edge values.
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronizes the active-low pad, debounces both
// edges and emits a registered level plus press/release/long-press pulses.
// Optional feature macro: BUTTON_DEBOUNCE_LONG_PRESS_EN builds the hold
// counter; without it long_press_pulse is tied to 0 and LONG_CYCLES is unused.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    button_debounce_if.slave   btn_if
);

    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_params
        $error("button_debounce: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 1");
    end

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

    logic             sync_btn_n;
    state_t           state_q, state_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (btn_if.btn_n),
        .q_o   (sync_btn_n)
    );

    // Next-state, debounce counter and event decode.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!sync_btn_n) begin
                    state_d   = PRESS_WAIT;
                    deb_cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (sync_btn_n) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_ONE;
                end
            end
            PRESSED: begin
                if (sync_btn_n) begin
                    state_d   = RELEASE_WAIT;
                    deb_cnt_d = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!sync_btn_n) begin
                    state_d = PRESSED;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    // FSM, debounce counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;

    // Hold counter: cleared while released, counts while the press persists,
    // saturates at LONG_CYCLES so only one long pulse fires per press. The
    // release edge does not count, keeping long and release pulses apart.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (!level_q) begin
            hold_d = '0;
        end else if (level_d && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + HOLD_ONE;
            long_d = (hold_q == HOLD_PRE);
        end
    end

    // Hold counter and long-press pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign btn_if.long_press_pulse = long_q;
`else
    assign btn_if.long_press_pulse = 1'b0;
`endif

    assign btn_if.btn_level     = level_q;
    assign btn_if.press_pulse   = press_q;
    assign btn_if.release_pulse = release_q;

endmodule : button_debounce
